// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives the data-memory request and stalls the pipe until ack or timeout.
// Latency: a request goes out in the same cycle it arrives, and ReadDataW/BusErrW update one cycle after the ack or timeout cycle.
// Backpressure: StallM holds upstream while waiting on DmemAck. MISALIGN_TRAP_EN adds misalignment trapping via MisalignW.
module mem_stage_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic        DmemReq,
    output logic        DmemWe,
    output logic [31:0] DmemAddr,
    output logic [31:0] DmemWData,
    output logic [3:0]  DmemBe,
    input  logic [31:0] DmemRData,
    input  logic        DmemAck,
    output logic [31:0] ReadDataW,
    output logic        BusErrW
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        MisalignW
`endif
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        is_store, is_load, access, misalign;
    logic        size_b, size_h, uns;
    logic        timeout_hit, done;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign is_store = MemWriteM;
    assign is_load  = !MemWriteM && (ResultSrcM == 2'b01);
    assign access   = is_store || is_load;

    // Undefined funct3 codes fall through to word size.
    assign size_b = (funct3M == 3'b000) || (funct3M == 3'b100);
    assign size_h = (funct3M == 3'b001) || (funct3M == 3'b101);
    assign uns    = funct3M[2];

`ifdef MISALIGN_TRAP_EN
    assign misalign = access && (state == S_IDLE) &&
                      ((size_h && ALUResultM[0]) ||
                       (!size_b && !size_h && (ALUResultM[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign DmemReq     = reset && ((state == S_WAIT) || (access && !misalign));
    assign timeout_hit = DmemReq && (state == S_WAIT) && !DmemAck && (cnt == CNT_LAST);
    assign done        = DmemReq && DmemAck;
    assign StallM      = DmemReq && !DmemAck && !timeout_hit;

    assign DmemWe   = is_store;
    assign DmemAddr = {ALUResultM[31:2], 2'b00};

    always_comb begin
        DmemBe    = 4'b1111;
        DmemWData = 32'h0;
        if (is_store) begin
            if (size_b) begin
                DmemBe    = 4'b0001 << ALUResultM[1:0];
                DmemWData = {4{WriteDataM[7:0]}};
            end else if (size_h) begin
                DmemBe    = 4'b0011 << {ALUResultM[1], 1'b0};
                DmemWData = {2{WriteDataM[15:0]}};
            end else begin
                DmemWData = WriteDataM;
            end
        end
    end

    always_comb begin
        ld_byte = 8'h0;
        case (ALUResultM[1:0])
            2'd0:    ld_byte = DmemRData[7:0];
            2'd1:    ld_byte = DmemRData[15:8];
            2'd2:    ld_byte = DmemRData[23:16];
            default: ld_byte = DmemRData[31:24];
        endcase
        ld_half = ALUResultM[1] ? DmemRData[31:16] : DmemRData[15:0];
        if (size_b)
            ld_ext = {{24{!uns && ld_byte[7]}}, ld_byte};
        else if (size_h)
            ld_ext = {{16{!uns && ld_half[15]}}, ld_half};
        else
            ld_ext = DmemRData;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            ReadDataW <= 32'h0;
            BusErrW   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            MisalignW <= 1'b0;
`endif
        end else begin
            BusErrW <= timeout_hit;
`ifdef MISALIGN_TRAP_EN
            MisalignW <= misalign;
            if (misalign && is_load)
                ReadDataW <= 32'h0;
`endif
            case (state)
                S_IDLE: begin
                    if (DmemReq && !DmemAck) begin
                        state <= S_WAIT;
                        cnt   <= 8'd0;
                    end
                end
                default: begin
                    if (DmemAck || timeout_hit)
                        state <= S_IDLE;
                    else
                        cnt <= cnt + 8'd1;
                end
            endcase
            if (done && is_load)
                ReadDataW <= ld_ext;
            else if (timeout_hit)
                ReadDataW <= 32'h0;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (TIMEOUT=4): stimulus pushes expected requests/responses, monitor checks them.
// Build with MISALIGN_TRAP_EN defined to cover the trap path.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [1:0]  ResultSrcM = 2'b00;
    logic [2:0]  funct3M = 3'b000;
    logic [31:0] ALUResultM = 32'h0;
    logic [31:0] WriteDataM = 32'h0;
    logic        StallM, DmemReq, DmemWe;
    logic [31:0] DmemAddr, DmemWData;
    logic [3:0]  DmemBe;
    logic [31:0] DmemRData = 32'h0;
    logic        DmemAck = 1'b0;
    logic [31:0] ReadDataW;
    logic        BusErrW;
`ifdef MISALIGN_TRAP_EN
    logic        MisalignW;
`endif

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .StallM(StallM), .DmemReq(DmemReq), .DmemWe(DmemWe), .DmemAddr(DmemAddr),
        .DmemWData(DmemWData), .DmemBe(DmemBe), .DmemRData(DmemRData), .DmemAck(DmemAck),
        .ReadDataW(ReadDataW), .BusErrW(BusErrW)
`ifdef MISALIGN_TRAP_EN
        , .MisalignW(MisalignW)
`endif
    );

    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; } req_t;
    typedef struct { logic [31:0] rd; logic berr; } rsp_t;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    logic [31:0] exp_hold = 32'h0;
    logic [31:0] rd_model = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: request fields whenever DmemReq is up, response one cycle after completion, hold otherwise.
    logic post = 1'b0;
    req_t mr;
    rsp_t ms;
    always @(negedge clk) begin
        if (mon_en) begin
            if (post) begin
                if (rsp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rsp_queue: completion with no expected response at %0t", $time);
                end else begin
                    ms = rsp_q.pop_front();
                    chk("ReadDataW", ReadDataW, ms.rd);
                    chk("BusErrW", {31'h0, BusErrW}, {31'h0, ms.berr});
                end
            end else begin
                chk("ReadDataW_hold", ReadDataW, exp_hold);
                chk("BusErrW_idle", {31'h0, BusErrW}, 32'h0);
            end
            post = 1'b0;
            if (DmemReq) begin
                if (req_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL req_queue: unexpected DmemReq addr=%h at %0t", DmemAddr, $time);
                end else begin
                    mr = req_q[0];
                    chk("DmemWe", {31'h0, DmemWe}, {31'h0, mr.we});
                    chk("DmemAddr", DmemAddr, mr.addr);
                    chk("DmemBe", {28'h0, DmemBe}, {28'h0, mr.be});
                    chk("DmemWData", DmemWData, mr.wd);
                    if (!StallM) begin
                        void'(req_q.pop_front());
                        post = 1'b1;
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        MemWriteM = 1'b0; ResultSrcM = 2'b00; DmemAck = 1'b0;
    endtask

    // Called at posedge+1; ack_after<0 means never acknowledge.
    task automatic do_access(input logic we, input logic ld, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                             input int ack_after, input int exp_stall,
                             input logic [3:0] ebe, input logic [31:0] ewd,
                             input logic [31:0] erd, input logic eberr);
        int  n;
        int  stalls;
        bit  fin;
        req_t r;
        rsp_t s;
        r.we = we; r.addr = {a[31:2], 2'b00}; r.be = ebe; r.wd = ewd;
        if (eberr || (ld && !we)) rd_model = erd;
        s.rd = rd_model; s.berr = eberr;
        req_q.push_back(r);
        rsp_q.push_back(s);
        MemWriteM = we; ResultSrcM = ld ? 2'b01 : 2'b00; funct3M = f3;
        ALUResultM = a; WriteDataM = wd; DmemRData = rd;
        DmemAck = (ack_after == 0);
        n = 0; stalls = 0; fin = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (StallM) stalls++;
            fin = !StallM;
            @(posedge clk); #1;
            if (fin) break;
            n++;
            DmemAck = (n == ack_after);
        end
        if (!fin) begin
            n_chk++; n_fail++;
            $display("FAIL access_timeout: access at %h never completed", a);
        end
        idle_inputs();
        exp_hold = rd_model;
        chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_ReadDataW", ReadDataW, 32'h0);
        chk("rst_BusErrW", {31'h0, BusErrW}, 32'h0);
        chk("rst_DmemReq", {31'h0, DmemReq}, 32'h0);
        chk("rst_StallM", {31'h0, StallM}, 32'h0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        //        we    ld    f3      addr          wdata         rdata         ack st  be       wdata_exp     rd_exp        berr
        do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0,  0, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0);
        do_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h0,        32'h80FFFF00, 3,  3, 4'b1111, 32'h0,        32'hFFFFFF80, 1'b0);
        do_access(1'b1, 1'b0, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        0,  0, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0);
        do_access(1'b1, 1'b0, 3'b000, 32'h301, 32'h000000A5, 32'h0,        2,  2, 4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0);
        do_access(1'b0, 1'b1, 3'b100, 32'h102, 32'h0,        32'h11223344, 1,  1, 4'b1111, 32'h0,        32'h00000022, 1'b0);
        do_access(1'b0, 1'b1, 3'b101, 32'h102, 32'h0,        32'h80017FFF, 0,  0, 4'b1111, 32'h0,        32'h00008001, 1'b0);
        do_access(1'b0, 1'b1, 3'b001, 32'h100, 32'h0,        32'h1234F00D, 0,  0, 4'b1111, 32'h0,        32'hFFFFF00D, 1'b0);
        do_access(1'b1, 1'b0, 3'b010, 32'h040, 32'hCAFEF00D, 32'h0,        0,  0, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0);
        do_access(1'b0, 1'b1, 3'b011, 32'h044, 32'h0,        32'h89ABCDEF, 0,  0, 4'b1111, 32'h0,        32'h89ABCDEF, 1'b0);
        // no ack: four stall cycles, then bus error and zeroed read data
        do_access(1'b0, 1'b1, 3'b010, 32'h080, 32'h0,        32'h12345678, -1, 4, 4'b1111, 32'h0,        32'h0,        1'b1);
        // ack lands on the timeout cycle and wins
        do_access(1'b0, 1'b1, 3'b010, 32'h084, 32'h0,        32'h5A5A5A5A, 4,  4, 4'b1111, 32'h0,        32'h5A5A5A5A, 1'b0);
`ifndef MISALIGN_TRAP_EN
        do_access(1'b0, 1'b1, 3'b001, 32'h103, 32'h0,        32'hBEEF0000, 0,  0, 4'b1111, 32'h0,        32'hFFFFBEEF, 1'b0);
        do_access(1'b0, 1'b1, 3'b010, 32'h102, 32'h0,        32'h01020304, 0,  0, 4'b1111, 32'h0,        32'h01020304, 1'b0);
`endif
        // store and load both flagged: store wins, read data holds
        do_access(1'b1, 1'b1, 3'b010, 32'h048, 32'h0BADF00D, 32'h0,        0,  0, 4'b1111, 32'h0BADF00D, 32'h0,        1'b0);

        // ack with no request is ignored
        DmemAck = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ack_StallM", {31'h0, StallM}, 32'h0);
            @(posedge clk); #1;
        end
        DmemAck = 1'b0;

        // reset during the second WAIT cycle abandons the access
        begin
            req_t r;
            r.we = 1'b0; r.addr = 32'h88; r.be = 4'b1111; r.wd = 32'h0;
            req_q.push_back(r);
            MemWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'b010; ALUResultM = 32'h88;
            DmemAck = 1'b0;
            @(negedge clk);
            chk("pre_rst_StallM", {31'h0, StallM}, 32'h1);
            repeat (2) @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            chk("in_rst_DmemReq", {31'h0, DmemReq}, 32'h0);
            chk("in_rst_StallM", {31'h0, StallM}, 32'h0);
            @(posedge clk); #1;
            reset = 1'b1;
            idle_inputs();
            req_q.delete();
            rsp_q.delete();
            rd_model = 32'h0;
            exp_hold = 32'h0;
            @(negedge clk);
            chk("post_rst_DmemReq", {31'h0, DmemReq}, 32'h0);
            chk("post_rst_StallM", {31'h0, StallM}, 32'h0);
            chk("post_rst_ReadDataW", ReadDataW, 32'h0);
            chk("post_rst_BusErrW", {31'h0, BusErrW}, 32'h0);
            repeat (6) @(posedge clk);
            #1;
        end

`ifdef MISALIGN_TRAP_EN
        do_access(1'b0, 1'b1, 3'b010, 32'h08C, 32'h0,        32'h00000077, 0,  0, 4'b1111, 32'h0,        32'h00000077, 1'b0);
        MemWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'b010; ALUResultM = 32'h101;
        @(negedge clk);
        chk("mis_DmemReq", {31'h0, DmemReq}, 32'h0);
        chk("mis_StallM", {31'h0, StallM}, 32'h0);
        @(posedge clk); #1;
        idle_inputs();
        rd_model = 32'h0;
        exp_hold = 32'h0;
        @(negedge clk);
        chk("mis_MisalignW", {31'h0, MisalignW}, 32'h1);
        chk("mis_ReadDataW", ReadDataW, 32'h0);
        @(negedge clk);
        chk("mis_MisalignW_clear", {31'h0, MisalignW}, 32'h0);
`endif

        repeat (3) @(posedge clk);
        chk("req_queue_empty", 32'(req_q.size()), 32'h0);
        chk("rsp_queue_empty", 32'(rsp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles spent in WAIT before the access is abandoned (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-low (reset==0 at posedge clk resets the block).
REQ-004 SHALL have port MemWriteM  input  1  store request from the Execute->Memory control register.
REQ-005 SHALL have port ResultSrcM  input  2  result select; 2'b01 marks a load.
REQ-006 SHALL have port funct3M  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port ALUResultM  input  32  byte address.
REQ-008 SHALL have port WriteDataM  input  32  store data, right-aligned.
REQ-009 SHALL have port StallM  output  1  holds all upstream stages while an access is pending.
REQ-010 SHALL have ports DmemReq out 1, DmemWe out 1, DmemAddr out 32 (word-aligned, bits[1:0]=0), DmemWData out 32, DmemBe out 4, DmemRData in 32, DmemAck in 1.
REQ-011 SHALL have ports ReadDataW  output  32  extended load data, and BusErrW  output  1  one-cycle timeout pulse.

Function
REQ-012 SHALL define an access as MemWriteM==1 (store) or ResultSrcM==2'b01 (load); MemWriteM has priority if both are set.
REQ-013 SHALL implement FSM states IDLE and WAIT, with a timeout counter active only in WAIT.
REQ-014 In IDLE with an access present, SHALL assert DmemReq combinationally in the same cycle, with DmemWe=MemWriteM.
REQ-015 IDLE with DmemAck==1 in the same cycle SHALL complete with zero stall and remain in IDLE.
REQ-016 IDLE with DmemAck==0 SHALL move to WAIT, clear the counter, and assert StallM in that cycle.
REQ-017 In WAIT, DmemReq and StallM SHALL stay high with DmemAddr, DmemWData and DmemBe unchanged until DmemAck==1; that ack cycle completes the access with StallM low and returns to IDLE.
REQ-018 In WAIT, the counter SHALL increment each cycle without ack; the cycle in which the count reaches TIMEOUT-1 without ack SHALL drop StallM, go to IDLE, pulse BusErrW on the next cycle, and load ReadDataW=0.
REQ-019 If an ack arrives in the same cycle as the timeout, the ack SHALL win (normal completion, no BusErrW).
REQ-020 SHALL ignore DmemAck when DmemReq is low.
REQ-021 On completion of a load, ReadDataW SHALL be registered one cycle after the ack cycle, and SHALL hold at all other times (including while stalled).
REQ-022 Load extraction SHALL take the byte lane ALUResultM[1:0], or the halfword lane ALUResultM[1]; B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-023 Stores SHALL use DmemBe: B = 4'b0001<<addr[1:0]; H = 4'b0011<<{addr[1],1'b0}; W = 4'b1111.
REQ-024 Stores SHALL replicate WriteDataM[7:0] into all four byte lanes for B, WriteDataM[15:0] into both halfword lanes for H, and pass W unchanged.
REQ-025 For loads, DmemBe SHALL be 4'b1111 and DmemWData SHALL be 0.
REQ-026 An undefined funct3 SHALL be treated as W.

Reset
REQ-027 reset==0 SHALL force state IDLE, counter 0, ReadDataW 0, and BusErrW 0 on that edge, including mid-WAIT.
REQ-028 While reset==0, DmemReq and StallM SHALL be 0.
REQ-029 A pending access SHALL be abandoned by reset, with no BusErrW.

Configuration
REQ-030 Macro MISALIGN_TRAP_EN SHALL enable misalignment checking.
REQ-031 With MISALIGN_TRAP_EN defined, an H access with addr[0]==1 or a W access with addr[1:0]!=0 SHALL NOT assert DmemReq and SHALL NOT stall.
REQ-032 With MISALIGN_TRAP_EN defined, output port MisalignW (1 bit) SHALL pulse one cycle later, and ReadDataW SHALL load 0 for a misaligned load.
REQ-033 Without MISALIGN_TRAP_EN, port MisalignW SHALL be absent, and misaligned accesses SHALL proceed using the lane selection of REQ-022/023 with the offending low address bits ignored.

Verification
REQ-034 LW at 0x100, DmemAck high in the same cycle, DmemRData=0xDEADBEEF -> StallM never high; ReadDataW=0xDEADBEEF next cycle.
REQ-035 LB at 0x103, ack after 3 wait cycles, DmemRData=0x80FF_FF00 -> StallM high 3 cycles, DmemAddr=0x100; ReadDataW=0xFFFFFF80.
REQ-036 SH at 0x202 with WriteDataM=0x1234ABCD -> DmemBe=4'b1100, DmemWData=0xABCDABCD, DmemWe=1.
REQ-037 LW, no ack, TIMEOUT=4 -> StallM high 4 cycles then low; BusErrW pulses once; ReadDataW=0.
REQ-038 reset driven to 0 in the 2nd WAIT cycle -> next cycle DmemReq=0, StallM=0, ReadDataW=0, BusErrW=0.
REQ-039 With MISALIGN_TRAP_EN defined, LW at 0x101 -> DmemReq stays 0; MisalignW pulses; ReadDataW=0.
